// File: rtl/miniRV_mem_pkg.sv
// Shared definitions for the miniRV load/store path.
//   F3_*      : RV32I load/store funct3 codes
//   state_e   : sequencer states
//   op_faults : decides whether a request is rejected without any memory access
package miniRV_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // Misaligned words, unused funct3 codes and unsigned stores are rejected.
    function automatic logic op_faults(input logic we, input logic [2:0] f3,
                                       input logic [1:0] addr_lo);
        logic bad;
        case (f3)
            F3_B, F3_H:   bad = 1'b0;
            F3_W:         bad = (addr_lo != 2'b00);
            F3_BU, F3_HU: bad = we;
            default:      bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bundles the execute-side request/response handshake and the data-memory bus.
//   master : execute stage + memory (drives req_*, mem_rdata)
//   slave  : lsu_ctrl (drives req_ready, resp_*, mem_* strobes/addr/wdata)
interface lsu_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_sw;
    logic              mem_sb;
    logic              mem_lw;
    logic              mem_lbu;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_wdata, mem_sw, mem_sb, mem_lw, mem_lbu
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_wdata, mem_sw, mem_sb, mem_lw, mem_lbu
    );
endinterface

// File: rtl/lsu_extend.sv
// Sign/zero extension of a sub-word load result.
//   f3_i   : load funct3 (B, H, BU, HU)
//   raw_i  : assembled bytes, byte 0 in [7:0], byte 1 in [15:8]
//   data_o : 32-bit extended result
module lsu_extend
    import miniRV_mem_pkg::*;
(
    input  logic [2:0]  f3_i,
    input  logic [15:0] raw_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = {16'h0000, raw_i};
        case (f3_i)
            F3_B:    data_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_H:    data_o = {{16{raw_i[15]}}, raw_i};
            F3_BU:   data_o = {24'h000000, raw_i[7:0]};
            F3_HU:   data_o = {16'h0000, raw_i};
            default: data_o = {16'h0000, raw_i};
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute stage and byte/word data memory.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : request/response handshake and memory bus (slave side)
// Halfwords are split into two byte accesses (addr, addr+1); the first loaded
// byte is buffered until the second arrives. Faulting requests skip memory.
module lsu_ctrl
    import miniRV_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    lsu_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [15:0]       ld_buf_q, ld_buf_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_fault_q, resp_fault_d;

    logic              accept;
    logic              is_word;
    logic              is_half;
    logic [15:0]       ext_raw;
    logic [31:0]       ext_data;

    assign is_word = (f3_q == F3_W);
    assign is_half = (f3_q == F3_H) || (f3_q == F3_HU);

    // In ACC1 the byte just read becomes the upper half of the result.
    assign ext_raw = (state_q == S_ACC1) ? {bus.mem_rdata[7:0], ld_buf_q[7:0]}
                                         : {8'h00, bus.mem_rdata[7:0]};

    lsu_extend u_extend (
        .f3_i   (f3_q),
        .raw_i  (ext_raw),
        .data_o (ext_data)
    );

    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_fault = resp_fault_q;

    always_comb begin
        state_d       = state_q;
        ld_buf_d      = ld_buf_q;
        resp_rdata_d  = resp_rdata_q;
        resp_fault_d  = resp_fault_q;
        bus.req_ready = (state_q == S_IDLE) && !rst;
        bus.resp_valid = (state_q == S_RESP) && !rst;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0;
        bus.mem_sw    = 1'b0;
        bus.mem_sb    = 1'b0;
        bus.mem_lw    = 1'b0;
        bus.mem_lbu   = 1'b0;
        accept        = bus.req_valid && bus.req_ready;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op_faults(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
                        state_d      = S_RESP;
                        resp_rdata_d = 32'h0;
                        resp_fault_d = 1'b1;
                    end else begin
                        state_d = S_ACC0;
                    end
                end
            end
            S_ACC0: begin
                bus.mem_addr = addr_q;
                if (is_word) begin
                    bus.mem_sw    = we_q;
                    bus.mem_lw    = !we_q;
                    bus.mem_wdata = we_q ? wdata_q : 32'h0;
                end else begin
                    bus.mem_sb    = we_q;
                    bus.mem_lbu   = !we_q;
                    bus.mem_wdata = we_q ? {24'h000000, wdata_q[7:0]} : 32'h0;
                end
                ld_buf_d = {8'h00, bus.mem_rdata[7:0]};
                if (is_half) begin
                    state_d = S_ACC1;
                end else begin
                    state_d      = S_RESP;
                    resp_fault_d = 1'b0;
                    if (we_q)         resp_rdata_d = 32'h0;
                    else if (is_word) resp_rdata_d = bus.mem_rdata;
                    else              resp_rdata_d = ext_data;
                end
            end
            S_ACC1: begin
                bus.mem_addr  = addr_q + ADDR_W'(1);
                bus.mem_sb    = we_q;
                bus.mem_lbu   = !we_q;
                bus.mem_wdata = we_q ? {24'h000000, wdata_q[15:8]} : 32'h0;
                state_d       = S_RESP;
                resp_fault_d  = 1'b0;
                resp_rdata_d  = we_q ? 32'h0 : ext_data;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
        endcase

        // A reset arriving mid-operation must not let the pending access land.
        if (rst) begin
            bus.mem_sw  = 1'b0;
            bus.mem_sb  = 1'b0;
            bus.mem_lw  = 1'b0;
            bus.mem_lbu = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            f3_q         <= F3_B;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            ld_buf_q     <= 16'h0000;
            resp_rdata_q <= 32'h0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_buf_q     <= ld_buf_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
        end
    end

endmodule
